doughnut_sequencer: RTL and testbench
=====================================

# doughnut_sequencer

Frame-synchronised controller for the OLED ring renderer. It sequences a pulsing ring animation on the 96x64 display: grow, hold, shrink, then advance colour. It updates ring radii and colour only at frame boundaries, so a frame never shows two radii. It also instantiates the per-pixel ring comparator and delivers the final pixel colour to the OLED colour mux.

## Interface
Parameters:
- R_MIN, 4: smallest inner radius, in pixels.
- R_MAX, 26: largest inner radius, in pixels; R_MAX + THICK must be ≤ 32.
- THICK, 2: ring thickness; r_outer = r_inner + THICK.
- FRAME_DIV, 2: frames per radius step, ≥ 1.
- HOLD_FRAMES, 30: frames spent in HOLD, ≥ 1.

Ports:
- clk25 input 1: system clock; all logic on rising edge.
- rst input 1: reset, synchronous, active-high.
- pixel_index input 13: current OLED pixel, 0..6143; x = index % 96, y = index / 96.
- start input 1: single-cycle request to begin animation.
- stop input 1: single-cycle request to end animation after the current pass.
- pixel_color output 16: RGB565 colour for pixel_index; registered.
- r_inner output 6: current inner radius.
- r_outer output 6: current outer radius.
- busy output 1: high in any state except IDLE.
- done output 1: one-cycle pulse on return to IDLE.
- state output 2: IDLE=0, GROW=1, HOLD=2, SHRINK=3.

## Operation
- Frame tick
  - tick = 1 on the first clk25 cycle where pixel_index == 0 and the registered previous pixel_index != 0.
  - pixel_index holds for several clk25 cycles per pixel, so tick fires exactly once per frame.
- Step enable
  - A frame counter counts ticks 0..FRAME_DIV-1.
  - step = tick when the counter equals FRAME_DIV-1; the counter then wraps to 0.
  - The counter clears on entry to GROW.
- Reset (rst): state=IDLE, r_inner=0, r_outer=0, palette index=0, stop_pend=0, hold counter=0, frame counter=0, pixel_color=0, busy=0, done=0.
- IDLE
  - start → GROW; r_inner=R_MIN, r_outer=R_MIN+THICK.
  - stop in IDLE is ignored.
  - start and stop in the same cycle: start the animation and set stop_pend, giving exactly one pass.
- GROW
  - On step: r_inner += 1.
  - When r_inner reaches R_MAX: go to HOLD and clear the hold counter.
- HOLD
  - Hold counter increments on every tick.
  - After HOLD_FRAMES ticks → SHRINK.
- SHRINK
  - On step: r_inner -= 1.
  - When r_inner reaches R_MIN, the pass ends and the palette index advances modulo 4.
  - If stop_pend: go to IDLE, clear r_inner, r_outer and stop_pend, and pulse done.
  - Otherwise: go to GROW.
- r_outer is always r_inner + THICK while busy and 0 in IDLE. No saturation logic is needed given the parameter constraint.
- stop
  - stop in any busy state sets stop_pend; it never aborts mid-pass.
  - start while busy is ignored.
- Palette (4 entries, RGB565): 0xF800, 0x07E0, 0x001F, 0xFFE0.
- Pixel path
  - dx = x − 48 and dy = y − 32, signed 8-bit.
  - d2 = dx² + dy², unsigned 12-bit; maximum 3328.
  - pixel_color = palette[idx] when busy and r_inner² ≤ d2 ≤ r_outer² (inclusive), else 0.
  - Squares are computed at 12 bits.

## Timing
- State, radii and palette index change on the clk25 edge after the step or tick that causes them.
- This is always within the first pixel-0 dwell, so every frame renders with one radius.
- pixel_color has 1 clk25 latency from pixel_index and register values.
- done is high for exactly 1 cycle, coincident with the cycle busy first reads 0.
- rst mid-operation returns all outputs to their reset values on the next edge; any pending stop is lost.

## Structure
- Shared package `oled_pkg`:
  - OLED_W=96, OLED_H=64, CX=48, CY=32, PIXELS=6144.
  - State enum.
  - 4-entry RGB565 palette constant.
- Sub-module `ring_pixel`: combinational d2 computation and radius compare (pixel_index, r_inner, r_outer, colour → hit colour). The output register lives in doughnut_sequencer.
- Top level holds tick detect, frame/hold counters, FSM and the palette index.

## Test plan
- Test-only parameters FRAME_DIV=1, HOLD_FRAMES=2, R_MIN=4, R_MAX=6, THICK=2.
- Pass timing: start with pixel_index sweeping 0..6143 at 4 clk25 per pixel → r_inner steps 4,5,6 on successive ticks, HOLD for 2 frames, SHRINK 5,4, then palette index 1 and GROW restarts.
- Single pass: start and stop in the same cycle → exactly one pass, then state=IDLE, done pulse of 1 cycle, r_inner=r_outer=0, pixel_color=0 for all pixels.
- Ring pixel hits: during GROW with r_inner=4, r_outer=6 → pixel (52,32) index 3124 gives 0xF800 (d2=16); index 3127 (d2=49) gives 0; pixel (48,32) gives 0.
- Mid-pass stop and ignored start: stop during HOLD → pass completes through SHRINK, then IDLE; a start asserted during HOLD is ignored, with no change in state or radius.
- Reset mid-GROW: rst at r_inner=5 → next cycle all outputs at reset values, and a subsequent start begins at r_inner=4 with palette index 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared OLED geometry, FSM state encoding and ring palette.
// Used by the ring sequencer and its per-pixel comparator.
package oled_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int CX     = 48;
  localparam int CY     = 32;
  localparam int PIXELS = 6144;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GROW   = 2'd1,
    HOLD   = 2'd2,
    SHRINK = 2'd3
  } state_t;

  // RGB565: red, green, blue, yellow (entry 0 in the low word)
  localparam logic [3:0][15:0] PALETTE = {
    16'hFFE0, 16'h001F, 16'h07E0, 16'hF800
  };

endpackage

// File: rtl/ring_pixel.sv
// Combinational ring hit test for one OLED pixel.
// Distance is squared to avoid a root; all squares fit 12 bits.
module ring_pixel
  import oled_pkg::*;
(
  input  logic [12:0] pixel_index,
  input  logic [5:0]  r_inner,
  input  logic [5:0]  r_outer,
  input  logic [15:0] color,
  output logic [15:0] hit_color
);

  logic [6:0]         px;
  logic [6:0]         py;
  logic signed [7:0]  dx;
  logic signed [7:0]  dy;
  logic signed [15:0] dxe;
  logic signed [15:0] dye;
  logic [15:0]        dx2;
  logic [15:0]        dy2;
  logic [11:0]        d2;
  logic [11:0]        ri_e;
  logic [11:0]        ro_e;
  logic [11:0]        ri2;
  logic [11:0]        ro2;

  assign px  = 7'(pixel_index % 13'(OLED_W));
  assign py  = 7'(pixel_index / 13'(OLED_W));
  assign dx  = {1'b0, px} - 8'(CX);
  assign dy  = {1'b0, py} - 8'(CY);
  assign dxe = 16'(dx);
  assign dye = 16'(dy);
  assign dx2 = dxe * dxe;
  assign dy2 = dye * dye;
  assign d2  = 12'(dx2 + dy2);

  assign ri_e = {6'd0, r_inner};
  assign ro_e = {6'd0, r_outer};
  assign ri2  = ri_e * ri_e;
  assign ro2  = ro_e * ro_e;

  // Inclusive band between the two radii
  always_comb begin
    hit_color = 16'd0;
    if (d2 >= ri2 && d2 <= ro2)
      hit_color = color;
  end

endmodule

// File: rtl/doughnut_sequencer.sv
// Frame-locked grow/hold/shrink ring animation controller.
// Radii move only on frame ticks; pixel colour is registered.
module doughnut_sequencer
  import oled_pkg::*;
#(
  parameter int R_MIN       = 4,
  parameter int R_MAX       = 26,
  parameter int THICK       = 2,
  parameter int FRAME_DIV   = 2,
  parameter int HOLD_FRAMES = 30
)(
  input  logic        clk25,
  input  logic        rst,
  input  logic [12:0] pixel_index,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] pixel_color,
  output logic [5:0]  r_inner,
  output logic [5:0]  r_outer,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
);

  localparam logic [5:0]  RMIN    = 6'(R_MIN);
  localparam logic [5:0]  RMAX    = 6'(R_MAX);
  localparam logic [5:0]  THK     = 6'(THICK);
  localparam logic [15:0] FD_LAST = 16'(FRAME_DIV - 1);
  localparam logic [15:0] HF_LAST = 16'(HOLD_FRAMES - 1);

  state_t      st, st_n;
  logic [5:0]  ri, ri_n;
  logic [1:0]  pal, pal_n;
  logic        sp, sp_n;
  logic [15:0] hc, hc_n;
  logic [15:0] fc, fc_n;
  logic        done_n;
  logic [12:0] prev;
  logic        tick;
  logic        step;
  logic [15:0] hit;

  assign tick    = (pixel_index == 13'd0) && (prev != 13'd0);
  assign step    = tick && (fc == FD_LAST);
  assign busy    = (st != IDLE);
  assign state   = st;
  assign r_inner = ri;
  assign r_outer = busy ? ri + THK : 6'd0;

  ring_pixel u_ring (
    .pixel_index (pixel_index),
    .r_inner     (ri),
    .r_outer     (r_outer),
    .color       (PALETTE[pal]),
    .hit_color   (hit)
  );

  // Next state, radius, palette and counters
  always_comb begin
    st_n   = st;
    ri_n   = ri;
    pal_n  = pal;
    sp_n   = sp;
    hc_n   = hc;
    done_n = 1'b0;
    fc_n   = fc;
    if (tick)
      fc_n = (fc == FD_LAST) ? 16'd0 : fc + 16'd1;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n = GROW;
          ri_n = RMIN;
          sp_n = stop;
          fc_n = 16'd0;
        end
      end
      GROW: begin
        sp_n = sp | stop;
        if (step) begin
          ri_n = ri + 6'd1;
          if (ri + 6'd1 == RMAX) begin
            st_n = HOLD;
            hc_n = 16'd0;
          end
        end
      end
      HOLD: begin
        sp_n = sp | stop;
        if (tick) begin
          hc_n = hc + 16'd1;
          if (hc == HF_LAST)
            st_n = SHRINK;
        end
      end
      SHRINK: begin
        sp_n = sp | stop;
        if (step) begin
          ri_n = ri - 6'd1;
          if (ri - 6'd1 == RMIN) begin
            pal_n = pal + 2'd1;
            if (sp) begin
              st_n   = IDLE;
              ri_n   = 6'd0;
              sp_n   = 1'b0;
              done_n = 1'b1;
            end else begin
              st_n = GROW;
              fc_n = 16'd0;
            end
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Control registers and registered pixel output
  always_ff @(posedge clk25) begin
    if (rst) begin
      st          <= IDLE;
      ri          <= 6'd0;
      pal         <= 2'd0;
      sp          <= 1'b0;
      hc          <= 16'd0;
      fc          <= 16'd0;
      done        <= 1'b0;
      pixel_color <= 16'd0;
    end else begin
      st          <= st_n;
      ri          <= ri_n;
      pal         <= pal_n;
      sp          <= sp_n;
      hc          <= hc_n;
      fc          <= fc_n;
      done        <= done_n;
      pixel_color <= busy ? hit : 16'd0;
    end
  end

  // Previous pixel index for frame-start detection
  always_ff @(posedge clk25) begin
    prev <= pixel_index;
  end

endmodule

// File: tb/tb_doughnut_sequencer.sv
// Randomized frame sweeps against a pass-level reference model.
// Model tracks ticks since pass start rather than FSM state.
module tb_doughnut_sequencer;
  import oled_pkg::*;

  localparam int RMN = 4;
  localparam int RMX = 6;
  localparam int TK  = 2;
  localparam int FD  = 1;
  localparam int HF  = 2;
  localparam int G   = RMX - RMN;
  localparam int L   = 2 * G + HF;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pixel_index;
  logic        start;
  logic        stop;
  logic [15:0] pixel_color;
  logic [5:0]  r_inner;
  logic [5:0]  r_outer;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  int m_busy = 0;
  int m_k    = 0;
  int m_pal  = 0;
  int m_stop = 0;
  int m_done = 0;
  int m_pix  = 0;
  int m_prev = 0;

  int pal_tab [4] = '{32'hF800, 32'h07E0, 32'h001F, 32'hFFE0};
  int tr_r    [6] = '{5, 6, 6, 6, 5, 4};
  int tr_s    [6] = '{1, 2, 2, 3, 3, 1};

  always #5 clk = ~clk;

  doughnut_sequencer #(
    .R_MIN       (RMN),
    .R_MAX       (RMX),
    .THICK       (TK),
    .FRAME_DIV   (FD),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk25       (clk),
    .rst         (rst),
    .pixel_index (pixel_index),
    .start       (start),
    .stop        (stop),
    .pixel_color (pixel_color),
    .r_inner     (r_inner),
    .r_outer     (r_outer),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  function automatic int cur_r();
    if (m_busy == 0) return 0;
    if (m_k < G) return RMN + m_k;
    if (m_k < G + HF) return RMX;
    return RMX - (m_k - G - HF);
  endfunction

  function automatic int cur_s();
    if (m_busy == 0) return 0;
    if (m_k < G) return 1;
    if (m_k < G + HF) return 2;
    return 3;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    int x, y, d2, r, tk;
    tk = (pixel_index == 0 && m_prev != 0) ? 1 : 0;
    m_prev = int'(pixel_index);
    x  = int'(pixel_index) % OLED_W - CX;
    y  = int'(pixel_index) / OLED_W - CY;
    d2 = x * x + y * y;
    r  = cur_r();
    m_pix = 0;
    if (m_busy != 0 && d2 >= r * r && d2 <= (r + TK) * (r + TK))
      m_pix = pal_tab[m_pal];
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_k = 0; m_pal = 0; m_stop = 0; m_pix = 0;
    end else if (m_busy == 0) begin
      if (start) begin
        m_busy = 1; m_k = 0; m_stop = int'(stop);
      end
    end else begin
      if (tk != 0) begin
        m_k++;
        if (m_k == L) begin
          m_k = 0;
          m_pal = (m_pal + 1) % 4;
          if (m_stop != 0) begin
            m_busy = 0; m_stop = 0; m_done = 1;
          end
        end
      end
      if (m_busy != 0 && stop) m_stop = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (done) n_done++;
    chk("state", int'(state), cur_s());
    chk("r_inner", int'(r_inner), cur_r());
    chk("r_outer", int'(r_outer), m_busy != 0 ? cur_r() + TK : 0);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
    chk("pixel", int'(pixel_color), m_pix);
  endtask

  task automatic drive_pix(input int idx, input int n);
    pixel_index = 13'(idx);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic frame();
    drive_pix(0, 4);
    repeat (30)
      drive_pix(int'($urandom_range(PIXELS - 1, 1)), int'($urandom_range(4, 1)));
  endtask

  initial begin
    int nf;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pixel_index = 13'd0;
    repeat (3) cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_r_inner", int'(r_inner), 0);
    chk("rst_r_outer", int'(r_outer), 0);
    chk("rst_pixel", int'(pixel_color), 0);
    rst = 1'b0;
    drive_pix(100, 2);

    // ring hits at r_inner=4, r_outer=6, palette 0
    pulse(1'b1, 1'b0);
    drive_pix(3124, 2);
    chk("hit_d2_16", int'(pixel_color), 32'hF800);
    drive_pix(3126, 2);
    chk("hit_d2_36", int'(pixel_color), 32'hF800);
    drive_pix(3127, 2);
    chk("miss_d2_49", int'(pixel_color), 0);
    drive_pix(3120, 2);
    chk("miss_centre", int'(pixel_color), 0);

    // first pass, one frame per step
    for (int i = 0; i < 6; i++) begin
      frame();
      chk("trace_r", int'(r_inner), tr_r[i]);
      chk("trace_state", int'(state), tr_s[i]);
    end

    // start ignored, stop deferred during HOLD
    nf = 0;
    while (nf < 20 && state != 2'd2) begin
      frame();
      nf++;
    end
    chk("reach_hold", int'(state), 2);
    pulse(1'b1, 1'b0);
    chk("ign_start_state", int'(state), 2);
    chk("ign_start_r", int'(r_inner), RMX);
    pulse(1'b0, 1'b1);
    chk("stop_keeps_hold", int'(state), 2);
    n_done = 0;
    nf = 0;
    while (nf < 20 && busy) begin
      frame();
      nf++;
    end
    chk("stop_idle", int'(state), 0);
    chk("stop_done_cnt", n_done, 1);

    // single pass from simultaneous start and stop
    drive_pix(200, 2);
    n_done = 0;
    pulse(1'b1, 1'b1);
    nf = 0;
    while (nf < 20 && busy) begin
      frame();
      nf++;
    end
    chk("one_pass_frames", nf, L);
    chk("one_pass_done", n_done, 1);
    chk("one_pass_rin", int'(r_inner), 0);
    chk("one_pass_rout", int'(r_outer), 0);
    frame();
    drive_pix(3124, 2);
    chk("idle_pixel", int'(pixel_color), 0);

    // reset during GROW at r_inner=5, palette 3
    pulse(1'b1, 1'b0);
    frame();
    chk("grow_r5", int'(r_inner), 5);
    drive_pix(3125, 2);
    chk("pal3_pixel", int'(pixel_color), 32'hFFE0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_r", int'(r_inner), 0);
    chk("mid_rst_rout", int'(r_outer), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pixel", int'(pixel_color), 0);
    pulse(1'b1, 1'b0);
    chk("restart_r", int'(r_inner), RMN);
    drive_pix(3124, 2);
    chk("restart_pal0", int'(pixel_color), 32'hF800);
    repeat (2) frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
